// File: rtl/aes128_key_expand.sv
// ---------------------------------------------------------------------------
// aes128_key_expand
//
// Iterative AES-128 key schedule. It produces the 11 round keys (round 0..10)
// one per accepted handshake on a valid/ready output stream. The S-box is not
// instantiated here. RotWord(w3) of the current key register goes out on
// sbox_word_o to one shared, purely combinational Sbox. Its SubWord result
// comes back on sbox_word_i in the same cycle. The next round key is then
// formed with the Rcon/XOR chain and registered on the accepting edge.
//
// Handshake: a round key transfers on a rising edge where rk_valid_o and
// rk_ready_i are both high. While rk_ready_i is low, rk_o, rk_idx_o and
// rk_valid_o hold their values. rk_valid_o never drops without a transfer,
// except on reset.
//
// Ports:
//   clk          in   1    single clock, rising edge
//   rst_n        in   1    synchronous active-low reset
//   start_i      in   1    begin an expansion (sampled only in IDLE)
//   key_i        in   128  cipher key, [127:96]=w0 .. [31:0]=w3
//   sbox_word_o  out  32   RotWord(w3) of the current key register
//   sbox_word_i  in   32   SubWord(sbox_word_o) from the external Sbox
//   rk_o         out  128  current round key, same word order as key_i
//   rk_idx_o     out  4    round index of rk_o, 0..10
//   rk_valid_o   out  1    rk_o / rk_idx_o valid
//   rk_ready_i   in   1    consumer accepts rk_o
//   busy_o       out  1    high whenever the FSM is not IDLE
//   done_o       out  1    one-cycle pulse after round 10 is accepted
//
// Optional feature, macro AES_KEYEXP_STORE_EN:
//   This adds an 11 x 128 round-key store and a registered read port for
//   fetching keys in reverse order, for example for decryption:
//   rk_rd_idx_i  in   4    read index, 0..10. Indices above 10 read 0.
//   rk_rd_data_o out  128  store[rk_rd_idx_i], one cycle after the index
// ---------------------------------------------------------------------------
module aes128_key_expand (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [127:0] key_i,
  output logic [31:0]  sbox_word_o,
  input  logic [31:0]  sbox_word_i,
  output logic [127:0] rk_o,
  output logic [3:0]   rk_idx_o,
  output logic         rk_valid_o,
  input  logic         rk_ready_i,
  output logic         busy_o,
  output logic         done_o
`ifdef AES_KEYEXP_STORE_EN
  ,
  input  logic [3:0]   rk_rd_idx_i,
  output logic [127:0] rk_rd_data_o
`endif
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  logic [0:0]   state_q;
  logic [127:0] key_q;
  logic [3:0]   idx_q;
  logic         valid_q;
  logic         done_q;

  logic         handshake;
  logic         last_round;
  logic [3:0]   idx_inc;
  logic [7:0]   rcon;
  logic [31:0]  temp;
  logic [31:0]  nw0, nw1, nw2, nw3;
  logic [127:0] next_key;

  // Rcon[idx+1]. The entry for idx 10 is never used, because the last
  // handshake does not advance the key.
  function automatic logic [7:0] rcon_of(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  assign handshake  = valid_q & rk_ready_i;
  assign last_round = (idx_q == LAST_ROUND);
  assign idx_inc    = idx_q + 4'd1;

  // RotWord(w3). It comes straight from the register, so it is 0 after reset.
  assign sbox_word_o = {key_q[23:0], key_q[31:24]};

  // Next round key: a single combinational pass through the external Sbox,
  // followed by the word-wise XOR chain.
  always_comb begin
    rcon     = rcon_of(idx_q);
    temp     = sbox_word_i ^ {rcon, 24'h000000};
    nw0      = key_q[127:96] ^ temp;
    nw1      = key_q[95:64]  ^ nw0;
    nw2      = key_q[63:32]  ^ nw1;
    nw3      = key_q[31:0]   ^ nw2;
    next_key = {nw0, nw1, nw2, nw3};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_RUN;
            key_q   <= key_i;
            idx_q   <= '0;
            valid_q <= 1'b1;
          end
        end
        ST_RUN: begin
          // start_i is deliberately ignored here. An expansion in progress
          // always runs to completion.
          if (handshake) begin
            if (last_round) begin
              // The round-10 key and index stay visible in IDLE.
              state_q <= ST_IDLE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              key_q <= next_key;
              idx_q <= idx_inc;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign rk_o       = key_q;
  assign rk_idx_o   = idx_q;
  assign rk_valid_o = valid_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = done_q;

`ifdef AES_KEYEXP_STORE_EN
  logic [127:0] store_q [0:10];
  logic [127:0] rd_data_q;

  // Round 0 is written when the key loads. Every later round is written on
  // the edge where it becomes the current key.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 11; i++) begin
        store_q[i] <= '0;
      end
    end else if (state_q == ST_IDLE && start_i) begin
      store_q[0] <= key_i;
    end else if (state_q == ST_RUN && handshake && !last_round) begin
      store_q[idx_inc] <= next_key;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rk_rd_idx_i <= LAST_ROUND) begin
      rd_data_q <= store_q[rk_rd_idx_i];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign rk_rd_data_o = rd_data_q;
`endif

endmodule

// File: tb/tb_aes128_key_expand.sv
module tb_aes128_key_expand;

  localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] KEY_ALT = 128'h000102030405060708090a0b0c0d0e0f;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic [127:0] key_i;
  logic [31:0]  sbox_word_o;
  logic [31:0]  sbox_word_i;
  logic [127:0] rk_o;
  logic [3:0]   rk_idx_o;
  logic         rk_valid_o;
  logic         rk_ready_i;
  logic         busy_o;
  logic         done_o;
`ifdef AES_KEYEXP_STORE_EN
  logic [3:0]   rk_rd_idx_i;
  logic [127:0] rk_rd_data_o;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  aes128_key_expand dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .key_i       (key_i),
    .sbox_word_o (sbox_word_o),
    .sbox_word_i (sbox_word_i),
    .rk_o        (rk_o),
    .rk_idx_o    (rk_idx_o),
    .rk_valid_o  (rk_valid_o),
    .rk_ready_i  (rk_ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o)
`ifdef AES_KEYEXP_STORE_EN
    ,
    .rk_rd_idx_i (rk_rd_idx_i),
    .rk_rd_data_o(rk_rd_data_o)
`endif
  );

  // ---------------- reference S-box (GF(2^8) inverse + affine) ----------------
  logic [7:0] sbox_tab [0:255];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gf_mul(inv, 8'(x));
      b = (x == 0) ? 8'h00 : inv;
      s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      sbox_tab[x] = s;
    end
  endtask

  assign sbox_word_i = {sbox_tab[sbox_word_o[31:24]], sbox_tab[sbox_word_o[23:16]],
                        sbox_tab[sbox_word_o[15:8]],  sbox_tab[sbox_word_o[7:0]]};

  // ---------------- reference key expansion (FIPS-197 word form) ----------------
  logic [127:0] exp_rk [0:10];

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- checking ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [131:0] got, input logic [131:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [131:0] exp_q [$];
  logic [127:0] seen [0:10];
  int           hs_count = 0;
  int           hs10_cyc = -100;

  logic         prev_stall = 1'b0;
  logic [127:0] prev_rk;
  logic [3:0]   prev_idx;

  always @(negedge clk) begin
    logic [131:0] e;
    if (rst_n) begin
      if (prev_stall) begin
        check("hold_rk",    {4'h0, rk_o},     {4'h0, prev_rk});
        check("hold_idx",   {128'h0, rk_idx_o}, {128'h0, prev_idx});
        check("hold_valid", {131'h0, rk_valid_o}, 132'h1);
      end
      if (rk_valid_o && rk_ready_i) begin
        if (exp_q.size() == 0) begin
          check("sb_empty", 132'(exp_q.size()), 132'h1);
        end else begin
          e = exp_q.pop_front();
          check("rk", {rk_idx_o, rk_o}, e);
        end
        if (rk_idx_o <= 4'd10) seen[rk_idx_o] = rk_o;
        hs_count++;
        if (rk_idx_o == 4'd10) hs10_cyc = cyc;
      end
      prev_stall = rk_valid_o && !rk_ready_i;
      prev_rk    = rk_o;
      prev_idx   = rk_idx_o;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  logic stall_mode = 1'b0;

  initial begin
    rk_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rk_ready_i = stall_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  task automatic start_run(input logic [127:0] key);
    model_expand(key);
    for (int r = 0; r < 11; r++) exp_q.push_back({4'(r), exp_rk[r]});
    @(posedge clk); #1;
    start_i = 1'b1;
    key_i   = key;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_idx(input logic [3:0] n);
    for (int i = 0; i < 200; i++) begin
      if (rk_valid_o && rk_idx_o == n) break;
      @(posedge clk); #1;
    end
    check("wait_idx", {128'h0, rk_idx_o}, {128'h0, n});
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      if (done_o) break;
      @(posedge clk); #1;
    end
    check("done_seen", {131'h0, done_o}, 132'h1);
    check("done_lat",  132'(cyc), 132'(hs10_cyc + 1));
    check("idle_rk",   {4'h0, rk_o}, {4'h0, exp_rk[10]});
    check("idle_idx",  {128'h0, rk_idx_o}, 132'd10);
    check("idle_busy", {130'h0, rk_valid_o, busy_o}, 132'h0);
    @(posedge clk); #1;
    check("done_pulse", {131'h0, done_o}, 132'h0);
    check("sb_drained", 132'(exp_q.size()), 132'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rk"},   {4'h0, rk_o}, 132'h0);
    check({tag, "_idx"},  {128'h0, rk_idx_o}, 132'h0);
    check({tag, "_flags"}, {129'h0, rk_valid_o, busy_o, done_o}, 132'h0);
    check({tag, "_sbox"}, {100'h0, sbox_word_o}, 132'h0);
  endtask

`ifdef AES_KEYEXP_STORE_EN
  task automatic store_read(input logic [3:0] idx, input logic [127:0] exp);
    @(posedge clk); #1;
    rk_rd_idx_i = idx;
    @(posedge clk); #1;
    check("store_rd", {idx, rk_rd_data_o}, {idx, exp});
  endtask
`endif

  // ---------------- main sequence ----------------
  initial begin
    build_sbox();
    rst_n   = 1'b0;
    start_i = 1'b0;
    key_i   = '0;
`ifdef AES_KEYEXP_STORE_EN
    rk_rd_idx_i = 4'd0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // FIPS-197 A.1 key, ready always high.
    hs_count = 0;
    start_run(KEY_A1);
    wait_done();
    check("a1_r1",  {4'h0, seen[1]},  {4'h0, A1_R1});
    check("a1_r10", {4'h0, seen[10]}, {4'h0, A1_R10});
    check("a1_count", 132'(hs_count), 132'd11);

`ifdef AES_KEYEXP_STORE_EN
    store_read(4'd10, A1_R10);
    store_read(4'd0,  KEY_A1);
    store_read(4'd5,  exp_rk[5]);
    store_read(4'd12, 128'h0);
`endif

    // All-zero key.
    hs_count = 0;
    start_run(128'h0);
    wait_done();
    check("zero_r1", {4'h0, seen[1]}, {4'h0, ZERO_R1});
    check("zero_count", 132'(hs_count), 132'd11);

    // Random backpressure with the A.1 key.
    stall_mode = 1'b1;
    hs_count = 0;
    start_run(KEY_A1);
    wait_done();
    check("stall_r10", {4'h0, seen[10]}, {4'h0, A1_R10});
    check("stall_count", 132'(hs_count), 132'd11);
    stall_mode = 1'b0;

    // A start with a different key at round 4 is ignored.
    start_run(KEY_A1);
    wait_idx(4'd4);
    check("busy_run", {131'h0, busy_o}, 132'h1);
    start_i = 1'b1;
    key_i   = KEY_ALT;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_done();
    check("restart_r10", {4'h0, seen[10]}, {4'h0, A1_R10});

    // Reset in the middle of an expansion.
    start_run(KEY_A1);
    wait_idx(4'd6);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    exp_q.delete();
`ifdef AES_KEYEXP_STORE_EN
    store_read(4'd3, 128'h0);
`endif
    rst_n = 1'b1;
    hs_count = 0;
    start_run(KEY_ALT);
    wait_done();
    check("post_rst_count", 132'(hs_count), 132'd11);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Safety net: the bench must always end on its own.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    n_bad++;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
